// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the multiplexed seven-segment scanner.
//   NDIG      - number of scanned digits
//   SEG_BLANK - active-low "all off" pattern for seg_en / seg_out
//   SEG_TABLE - active-low {dp,g,f,e,d,c,b,a} codes for hex nibbles 0-F (dp bit off)
package seg_pkg;

  localparam int unsigned NDIG = 8;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Entry i is the code for nibble i (listed high index first).
  localparam logic [15:0][7:0] SEG_TABLE = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

endpackage

// File: rtl/seg_decode.sv
// seg_decode: combinational hex-to-seven-segment decoder, active-low outputs.
//   nibble - 4-bit hex value
//   dp     - decimal point request, 1 = lit
//   seg    - {dp,g,f,e,d,c,b,a}, active-low
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  logic [7:0] code;

  always_comb begin
    code = SEG_TABLE[nibble];
    seg  = {~dp, code[6:0]};
  end

endmodule

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed driver for an 8-digit seven-segment display.
//   clk      - system clock
//   rst      - asynchronous reset, active-low
//   hz       - scan-rate square wave, synchronous to clk; each rising edge advances one digit
//   data     - eight hex nibbles, nibble i belongs to digit i
//   dp       - decimal point request per digit, 1 = lit
//   dig_mask - digit enable per digit, 1 = digit may light
//   seg_en   - registered digit select, active-low, at most one bit low
//   seg_out  - registered segments {dp,g,f,e,d,c,b,a}, active-low
// Inputs are sampled into shadow registers once per frame (at the 7 -> 0 wrap) so a
// mid-frame change never shows a mix of old and new values.
module seg_scan
  import seg_pkg::*;
#(
  parameter int unsigned NDIG     = 8,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hz,
  input  logic [31:0] data,
  input  logic [7:0]  dp,
  input  logic [7:0]  dig_mask,
  output logic [7:0]  seg_en,
  output logic [7:0]  seg_out
);

  localparam int unsigned IdxW = $clog2(NDIG);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NDIG - 1);

  logic            hz_q, hz_q2;
  logic            tick;
  logic [IdxW-1:0] idx, idx_d;
  logic            frame_end;

  logic [31:0]     data_sh;
  logic [7:0]      dp_sh, mask_sh;

  logic [3:0]      cur_nib;
  logic            cur_dp;
  logic            tail_zero;
  logic            blank;
  logic [7:0]      dec_seg;
  logic [7:0]      seg_en_d, seg_out_d;

  assign tick      = hz_q & ~hz_q2;
  assign frame_end = tick && (idx == IdxLast);

  always_comb begin
    idx_d = idx;
    if (tick) begin
      idx_d = (idx == IdxLast) ? '0 : idx + 1'b1;
    end
  end

  always_comb begin
    cur_nib   = data_sh[{idx, 2'b00} +: 4];
    cur_dp    = dp_sh[idx];
    // Nibbles idx..7 are all zero exactly when the shifted-down word is zero.
    tail_zero = (data_sh >> {idx, 2'b00}) == 32'd0;
    blank     = ~mask_sh[idx];
    if ((BLANK_LZ != 0) && (idx != '0) && tail_zero) begin
      blank = 1'b1;
    end
    seg_en_d  = SEG_BLANK;
    seg_out_d = SEG_BLANK;
    if (!blank) begin
      seg_en_d  = ~(8'd1 << idx);
      seg_out_d = dec_seg;
    end
  end

  seg_decode u_decode (
    .nibble (cur_nib),
    .dp     (cur_dp),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hz_q    <= 1'b0;
      hz_q2   <= 1'b0;
      idx     <= '0;
      data_sh <= '0;
      dp_sh   <= '0;
      mask_sh <= '0;
      seg_en  <= SEG_BLANK;
      seg_out <= SEG_BLANK;
    end else begin
      hz_q    <= hz;
      hz_q2   <= hz_q;
      idx     <= idx_d;
      if (frame_end) begin
        data_sh <= data;
        dp_sh   <= dp;
        mask_sh <= dig_mask;
      end
      seg_en  <= seg_en_d;
      seg_out <= seg_out_d;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: checks seg_scan with leading-zero blanking on (dut) and off (dut0), driven
// from a shared stimulus. Each hz pulse pushes the expected digit onto a scoreboard that
// is popped once the registered outputs have settled.
module tb_seg_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        hz;
  logic [31:0] data;
  logic [7:0]  dp, dig_mask;
  logic [7:0]  seg_en, seg_out, seg_en0, seg_out0;

  always #5 clk = ~clk;

  seg_scan #(.NDIG(8), .BLANK_LZ(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .hz       (hz),
    .data     (data),
    .dp       (dp),
    .dig_mask (dig_mask),
    .seg_en   (seg_en),
    .seg_out  (seg_out)
  );

  seg_scan #(.NDIG(8), .BLANK_LZ(0)) dut0 (
    .clk      (clk),
    .rst      (rst),
    .hz       (hz),
    .data     (data),
    .dp       (dp),
    .dig_mask (dig_mask),
    .seg_en   (seg_en0),
    .seg_out  (seg_out0)
  );

  typedef struct {
    logic [31:0] d;
    logic [7:0]  p, m, en, out, en0, out0;
  } vec_t;

  typedef struct {
    int         tag;
    logic [7:0] en, out, en0, out0;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   tag   = 0;

  function automatic void add(input logic [31:0] d, input logic [7:0] p, m,
                              input logic [7:0] en, out, en0, out0);
    vec_t v;
    v.d = d; v.p = p; v.m = m;
    v.en = en; v.out = out; v.en0 = en0; v.out0 = out0;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string nm, input int t, input logic [7:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h want %h", nm, t, act, exp);
    end
  endtask

  // One hz rising edge; outputs reflect the new digit 3 clk after the edge.
  task automatic pulse(input logic [7:0] en, out, en0, out0);
    exp_t e;
    e.tag = tag; e.en = en; e.out = out; e.en0 = en0; e.out0 = out0;
    sb.push_back(e);
    tag++;
    hz = 1'b1;
    repeat (4) @(negedge clk);
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL scoreboard empty at step %0d", tag);
    end else begin
      e = sb.pop_front();
      chk("seg_en",   e.tag, seg_en,   e.en);
      chk("seg_out",  e.tag, seg_out,  e.out);
      chk("seg_en0",  e.tag, seg_en0,  e.en0);
      chk("seg_out0", e.tag, seg_out0, e.out0);
    end
    hz = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [7:0] e_en;
    // Frame 0: shadows still reset (mask 0) -> fully blank.
    for (int i = 1; i < 8; i++) add(32'h0000_1234, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    // Frame 1: 1234, data changes to ABCD while idx=3.
    add(32'h0000_1234, 8'h00, 8'hFF, 8'hFE, 8'h99, 8'hFE, 8'h99);
    add(32'h0000_1234, 8'h00, 8'hFF, 8'hFD, 8'hB0, 8'hFD, 8'hB0);
    add(32'h0000_1234, 8'h00, 8'hFF, 8'hFB, 8'hA4, 8'hFB, 8'hA4);
    add(32'h0000_1234, 8'h00, 8'hFF, 8'hF7, 8'hF9, 8'hF7, 8'hF9);
    add(32'h0000_ABCD, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hEF, 8'hC0);
    add(32'h0000_ABCD, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hDF, 8'hC0);
    add(32'h0000_ABCD, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'hC0);
    add(32'h0000_ABCD, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'hC0);
    // Frame 2: ABCD; new data and dp arrive mid-frame.
    add(32'h0000_ABCD, 8'h00, 8'hFF, 8'hFE, 8'hA1, 8'hFE, 8'hA1);
    add(32'h0000_ABCD, 8'h00, 8'hFF, 8'hFD, 8'hC6, 8'hFD, 8'hC6);
    add(32'h0000_ABCD, 8'h00, 8'hFF, 8'hFB, 8'h83, 8'hFB, 8'h83);
    add(32'h0000_ABCD, 8'h00, 8'hFF, 8'hF7, 8'h88, 8'hF7, 8'h88);
    add(32'h9876_5EF1, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hEF, 8'hC0);
    add(32'h9876_5EF1, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hDF, 8'hC0);
    add(32'h9876_5EF1, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'hC0);
    add(32'h9876_5EF1, 8'h04, 8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'hC0);
    // Frame 3: 98765EF1 with dp on digit 2; zero data and dp/mask change mid-frame.
    add(32'h9876_5EF1, 8'h04, 8'hFF, 8'hFE, 8'hF9, 8'hFE, 8'hF9);
    add(32'h9876_5EF1, 8'h04, 8'hFF, 8'hFD, 8'h8E, 8'hFD, 8'h8E);
    add(32'h9876_5EF1, 8'h04, 8'hFF, 8'hFB, 8'h06, 8'hFB, 8'h06);
    add(32'h9876_5EF1, 8'h04, 8'hFF, 8'hF7, 8'h92, 8'hF7, 8'h92);
    add(32'h0000_0000, 8'h01, 8'hFE, 8'hEF, 8'h82, 8'hEF, 8'h82);
    add(32'h0000_0000, 8'h01, 8'hFE, 8'hDF, 8'hF8, 8'hDF, 8'hF8);
    add(32'h0000_0000, 8'h01, 8'hFE, 8'hBF, 8'h80, 8'hBF, 8'h80);
    add(32'h0000_0000, 8'h01, 8'hFE, 8'h7F, 8'h90, 8'h7F, 8'h90);
    // Frame 4: digit 0 masked, dp request must not light it.
    add(32'h0000_0000, 8'h01, 8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    add(32'h0000_0000, 8'h01, 8'hFE, 8'hFF, 8'hFF, 8'hFD, 8'hC0);
    add(32'h0000_0000, 8'h01, 8'hFE, 8'hFF, 8'hFF, 8'hFB, 8'hC0);
    add(32'h0000_0000, 8'h01, 8'hFE, 8'hFF, 8'hFF, 8'hF7, 8'hC0);
    add(32'h0000_0000, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hEF, 8'hC0);
    add(32'h0000_0000, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hDF, 8'hC0);
    add(32'h0000_0000, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hBF, 8'hC0);
    add(32'h0000_0000, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'h7F, 8'hC0);
    // Frame 5: digit 0 unmasked, "0." = 40.
    add(32'h0000_0000, 8'h01, 8'hFF, 8'hFE, 8'h40, 8'hFE, 8'h40);

    rst      = 1'b0;
    hz       = 1'b0;
    data     = 32'h0000_1234;
    dp       = 8'h00;
    dig_mask = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_seg_en",   -1, seg_en,   8'hFF);
    chk("rst_seg_out",  -1, seg_out,  8'hFF);
    chk("rst_seg_en0",  -1, seg_en0,  8'hFF);
    chk("rst_seg_out0", -1, seg_out0, 8'hFF);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_seg_en", -1, seg_en, 8'hFF);

    foreach (vecs[i]) begin
      data     = vecs[i].d;
      dp       = vecs[i].p;
      dig_mask = vecs[i].m;
      pulse(vecs[i].en, vecs[i].out, vecs[i].en0, vecs[i].out0);
    end

    // hz held high: one advance on the rising edge, then nothing.
    hz = 1'b1;
    repeat (4) @(negedge clk);
    chk("hold_seg_en",   0, seg_en,   8'hFF);
    chk("hold_seg_en0",  0, seg_en0,  8'hFD);
    chk("hold_seg_out0", 0, seg_out0, 8'hC0);
    repeat (1000) @(negedge clk);
    chk("hold_seg_en",   1, seg_en,   8'hFF);
    chk("hold_seg_en0",  1, seg_en0,  8'hFD);
    chk("hold_seg_out0", 1, seg_out0, 8'hC0);
    hz = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 2; i < 8; i++) begin
      e_en = ~(8'd1 << i);
      pulse(8'hFF, 8'hFF, e_en, 8'hC0);
    end
    pulse(8'hFE, 8'h40, 8'hFE, 8'h40);

    // Reset between clock edges mid-frame.
    for (int i = 1; i < 4; i++) begin
      e_en = ~(8'd1 << i);
      pulse(8'hFF, 8'hFF, e_en, 8'hC0);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chk("arst_seg_en",   -1, seg_en,   8'hFF);
    chk("arst_seg_out",  -1, seg_out,  8'hFF);
    chk("arst_seg_en0",  -1, seg_en0,  8'hFF);
    chk("arst_seg_out0", -1, seg_out0, 8'hFF);
    chk("arst_idx",      -1, {5'd0, dut0.idx}, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    // Shadows cleared: blank until the wrap, which must come on the 8th pulse.
    for (int i = 1; i < 8; i++) pulse(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    pulse(8'hFE, 8'h40, 8'hFE, 8'h40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
